pic_control_logic: RTL and testbench

Clocked control core of the 8259 PIC. It consumes the ICW/OCW strobes and the data byte decoded by the bus read/write interface. It also holds the IRR, ISR and IMR registers and resolves fixed priority (IR0 highest). It runs the two-pulse INTA sequence, presents the interrupt vector, and returns the register selected by OCW3/A0 to the read/write interface for CPU reads.

---
 rtl/pic_control_logic.sv | 236 +++++++++++++++++++++++
 tb/tb_pic_control_logic.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pic_control_logic.sv
// pic_control_logic: 8259-style control core (IRR/ISR/IMR, fixed priority, two-pulse INTA).
// Build macro PIC_AEOI_EN enables automatic EOI selected by ICW4 bit 1.
module pic_control_logic #(
    parameter int IR_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:1] icw_stb,
    input  logic [3:1] ocw_stb,
    input  logic [7:0] din,
    input  logic       init_done,
    input  logic       a0,
    input  logic [7:0] ir,
    input  logic       inta_n,
    output logic       int_o,
    output logic [7:0] rd_data,
    output logic [7:0] vec,
    output logic       vec_oe
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:1] icw_q, icw_prev_q, icw_fire;
    logic [3:1] ocw_q, ocw_prev_q, ocw_fire;
    logic [7:0] din_q;
    logic [7:0] sync_q [IR_SYNC_STAGES];
    logic [7:0] ir_sync, ir_prev_q, ir_rise;
    logic [7:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
    logic       rsel_q, rsel_d, ltim_q, ltim_d, aeoi_q;
    logic [4:0] base_q, base_d;
    logic [2:0] idx_q, idx_d, cand_idx;
    logic       spur_q, spur_d, cand_vld;
    logic       inta_prev_q, inta_fall, inta_rise;
    logic       int_q, int_d, vec_oe_q, vec_oe_d;
    logic [7:0] vec_q, vec_d;
    logic [7:0] req, blocked;
    logic [7:0] eoi_mask, set_mask, aeoi_mask;
    logic       icw3_unused;

    assign icw_fire    = icw_q & ~icw_prev_q;
    assign ocw_fire    = ocw_q & ~ocw_prev_q;
    assign ir_sync     = sync_q[IR_SYNC_STAGES-1];
    assign ir_rise     = ir_sync & ~ir_prev_q;
    assign inta_fall   = inta_prev_q & ~inta_n;
    assign inta_rise   = ~inta_prev_q & inta_n;
    assign icw3_unused = icw_fire[3];

    assign int_o   = int_q;
    assign vec     = vec_q;
    assign vec_oe  = vec_oe_q;
    assign rd_data = a0 ? imr_q : (rsel_q ? isr_q : irr_q);

`ifdef PIC_AEOI_EN
    logic aeoi_d;

    // AEOI mode bit: cleared by ICW1, loaded by ICW4
    always_comb begin
        aeoi_d = aeoi_q;
        if (icw_fire[1]) begin
            aeoi_d = 1'b0;
        end else if (icw_fire[4]) begin
            aeoi_d = din_q[1];
        end else begin
            aeoi_d = aeoi_q;
        end
    end

    // AEOI mode register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aeoi_q <= 1'b0;
        end else begin
            aeoi_q <= aeoi_d;
        end
    end
`else
    logic icw4_unused;
    assign aeoi_q      = 1'b0;
    assign icw4_unused = icw_fire[4];
`endif

    // Fixed priority: lowest unmasked request not shadowed by an equal/higher in-service level
    always_comb begin
        req      = irr_q & ~imr_q;
        blocked  = 8'd0;
        cand_vld = 1'b0;
        cand_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            blocked[i] = isr_q[i] | ((i > 0) ? blocked[(i > 0) ? i - 1 : 0] : 1'b0);
            if (!cand_vld && !blocked[i] && req[i]) begin
                cand_vld = 1'b1;
                cand_idx = 3'(i);
            end else begin
                cand_vld = cand_vld;
            end
        end
    end

    // Next-state: INTA FSM, command decode, IRR/ISR/IMR update; ICW1 overrides everything
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        spur_d    = spur_q;
        vec_d     = vec_q;
        vec_oe_d  = vec_oe_q;
        imr_d     = imr_q;
        rsel_d    = rsel_q;
        ltim_d    = ltim_q;
        base_d    = base_q;
        eoi_mask  = 8'd0;
        set_mask  = 8'd0;
        aeoi_mask = 8'd0;
        case (state_q)
            ST_IDLE: begin
                if (inta_fall) begin
                    state_d  = ST_ACK1;
                    idx_d    = cand_vld ? cand_idx : 3'd7;
                    spur_d   = ~cand_vld;
                    set_mask = cand_vld ? (8'd1 << cand_idx) : 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK1: state_d = inta_rise ? ST_ACK2 : ST_ACK1;
            ST_ACK2: begin
                if (inta_fall) begin
                    vec_oe_d = 1'b1;
                    vec_d    = {base_q, idx_q};
                end else if (inta_rise && vec_oe_q) begin
                    vec_oe_d  = 1'b0;
                    state_d   = ST_IDLE;
                    aeoi_mask = (aeoi_q && !spur_q) ? (8'd1 << idx_q) : 8'd0;
                end else begin
                    state_d = ST_ACK2;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (ocw_fire[1]) begin
            imr_d = din_q;
        end else begin
            imr_d = imr_q;
        end
        if (ocw_fire[2]) begin
            case (din_q[7:5])
                3'b001:  eoi_mask = isr_q & (~isr_q + 8'd1);
                3'b011:  eoi_mask = 8'd1 << din_q[2:0];
                default: eoi_mask = 8'd0;
            endcase
        end else begin
            eoi_mask = 8'd0;
        end
        if (ocw_fire[3] && din_q[1]) begin
            rsel_d = din_q[0];
        end else begin
            rsel_d = rsel_q;
        end
        if (icw_fire[2]) begin
            base_d = din_q[7:3];
        end else begin
            base_d = base_q;
        end
        irr_d = (ltim_q ? ir_sync : (ir_sync & (irr_q | ir_rise))) & ~set_mask;
        isr_d = (isr_q & ~eoi_mask & ~aeoi_mask) | set_mask;
        int_d = (state_q == ST_IDLE) && cand_vld && init_done;
        if (icw_fire[1]) begin
            imr_d    = 8'd0;
            isr_d    = 8'd0;
            irr_d    = 8'd0;
            rsel_d   = 1'b0;
            ltim_d   = din_q[3];
            base_d   = 5'd0;
            state_d  = ST_IDLE;
            idx_d    = 3'd0;
            spur_d   = 1'b0;
            vec_oe_d = 1'b0;
            int_d    = 1'b0;
        end else begin
            ltim_d = ltim_q;
        end
    end

    // All control-core state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icw_q       <= 4'd0;
            icw_prev_q  <= 4'd0;
            ocw_q       <= 3'd0;
            ocw_prev_q  <= 3'd0;
            din_q       <= 8'd0;
            for (int i = 0; i < IR_SYNC_STAGES; i++) sync_q[i] <= 8'd0;
            ir_prev_q   <= 8'd0;
            irr_q       <= 8'd0;
            isr_q       <= 8'd0;
            imr_q       <= 8'd0;
            rsel_q      <= 1'b0;
            ltim_q      <= 1'b0;
            base_q      <= 5'd0;
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            spur_q      <= 1'b0;
            inta_prev_q <= 1'b1;
            int_q       <= 1'b0;
            vec_q       <= 8'd0;
            vec_oe_q    <= 1'b0;
        end else begin
            icw_q       <= icw_stb;
            icw_prev_q  <= icw_q;
            ocw_q       <= ocw_stb;
            ocw_prev_q  <= ocw_q;
            din_q       <= din;
            sync_q[0]   <= ir;
            for (int i = 1; i < IR_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            ir_prev_q   <= ir_sync;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            imr_q       <= imr_d;
            rsel_q      <= rsel_d;
            ltim_q      <= ltim_d;
            base_q      <= base_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            spur_q      <= spur_d;
            inta_prev_q <= inta_n;
            int_q       <= int_d;
            vec_q       <= vec_d;
            vec_oe_q    <= vec_oe_d;
        end
    end

endmodule

// File: tb/tb_pic_control_logic.sv
// Directed bench for pic_control_logic: init, priority, masking, EOI, spurious, AEOI, reset.
module tb_pic_control_logic;

    logic       clk;
    logic       rst_n;
    logic [4:1] icw_stb;
    logic [3:1] ocw_stb;
    logic [7:0] din;
    logic       init_done;
    logic       a0;
    logic [7:0] ir;
    logic       inta_n;
    logic       int_o;
    logic [7:0] rd_data;
    logic [7:0] vec;
    logic       vec_oe;

    int         n_vec;
    int         n_err;
    logic [7:0] vec_seen;
    logic       oe_seen;
    logic       oe_after;
    logic [7:0] aeoi_isr_exp;

    pic_control_logic #(.IR_SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .icw_stb   (icw_stb),
        .ocw_stb   (ocw_stb),
        .din       (din),
        .init_done (init_done),
        .a0        (a0),
        .ir        (ir),
        .inta_n    (inta_n),
        .int_o     (int_o),
        .rd_data   (rd_data),
        .vec       (vec),
        .vec_oe    (vec_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic wr_icw(input int n, input logic [7:0] data);
        din        = data;
        icw_stb[n] = 1'b1;
        ticks(1);
        icw_stb    = 4'd0;
        ticks(2);
    endtask

    task automatic wr_ocw(input int n, input logic [7:0] data);
        din        = data;
        ocw_stb[n] = 1'b1;
        ticks(1);
        ocw_stb    = 3'd0;
        ticks(2);
    endtask

    task automatic inta_cycle();
        inta_n = 1'b0;
        ticks(2);
        inta_n = 1'b1;
        ticks(2);
        inta_n = 1'b0;
        ticks(1);
        vec_seen = vec;
        oe_seen  = vec_oe;
        ticks(1);
        inta_n = 1'b1;
        ticks(1);
        oe_after = vec_oe;
        ticks(1);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        icw_stb   = 4'd0;
        ocw_stb   = 3'd0;
        din       = 8'd0;
        init_done = 1'b0;
        a0        = 1'b0;
        ir        = 8'd0;
        inta_n    = 1'b1;
        ticks(2);
        chk("rst_int", {7'd0, int_o}, 8'h00);
        chk("rst_vec", vec, 8'h00);
        chk("rst_vec_oe", {7'd0, vec_oe}, 8'h00);
        chk("rst_rd_irr", rd_data, 8'h00);
        a0 = 1'b1;
        #1;
        chk("rst_rd_imr", rd_data, 8'h00);
        a0    = 1'b0;
        rst_n = 1'b1;
        ticks(1);

        wr_icw(1, 8'h13);
        wr_icw(2, 8'h40);
        wr_icw(4, 8'h01);
        init_done = 1'b1;
        wr_ocw(1, 8'h00);

        ir = 8'h08;
        ticks(3);
        chk("ir_lat_early", {7'd0, int_o}, 8'h00);
        ticks(1);
        chk("ir_lat_int", {7'd0, int_o}, 8'h01);
        chk("irr_ir3", rd_data, 8'h08);
        inta_cycle();
        chk("vec_ir3", vec_seen, 8'h43);
        chk("vec_oe_ack2", {7'd0, oe_seen}, 8'h01);
        chk("vec_oe_drop", {7'd0, oe_after}, 8'h00);
        chk("int_after_ack", {7'd0, int_o}, 8'h00);
        wr_ocw(3, 8'h0B);
        chk("isr_ir3", rd_data, 8'h08);

        ir = 8'h28;
        ticks(5);
        chk("ir5_blocked", {7'd0, int_o}, 8'h00);
        ir = 8'h2A;
        ticks(5);
        chk("ir1_preempt", {7'd0, int_o}, 8'h01);
        inta_cycle();
        chk("vec_ir1", vec_seen, 8'h41);
        chk("isr_nested", rd_data, 8'h0A);

        wr_ocw(2, 8'h20);
        chk("eoi_nonspec", rd_data, 8'h08);
        wr_ocw(2, 8'h63);
        chk("eoi_spec3", rd_data, 8'h00);
        wr_ocw(2, 8'h40);
        chk("ocw2_ignored", rd_data, 8'h00);

        ir = 8'h00;
        ticks(4);
        wr_ocw(1, 8'h08);
        ir = 8'h08;
        ticks(5);
        chk("masked_int", {7'd0, int_o}, 8'h00);
        wr_ocw(3, 8'h0A);
        chk("rd_irr_masked", rd_data, 8'h08);
        a0 = 1'b1;
        #1;
        chk("rd_imr", rd_data, 8'h08);
        a0 = 1'b0;
        wr_ocw(3, 8'h08);
        chk("ocw3_keep_sel", rd_data, 8'h08);

        wr_ocw(1, 8'h00);
        ticks(1);
        chk("unmask_int", {7'd0, int_o}, 8'h01);
        ir = 8'h00;
        ticks(5);
        chk("drop_int", {7'd0, int_o}, 8'h00);
        wr_ocw(3, 8'h0B);
        inta_cycle();
        chk("vec_spurious", vec_seen, 8'h47);
        chk("isr_spurious", rd_data, 8'h00);

        wr_icw(1, 8'h13);
        chk("icw1_rsel_irr", rd_data, 8'h00);
        wr_icw(2, 8'h40);
        wr_icw(4, 8'h03);
        wr_ocw(1, 8'h00);
        wr_ocw(3, 8'h0B);
        ir = 8'h04;
        ticks(5);
        chk("aeoi_int", {7'd0, int_o}, 8'h01);
        inta_cycle();
        chk("vec_ir2", vec_seen, 8'h42);
`ifdef PIC_AEOI_EN
        aeoi_isr_exp = 8'h00;
`else
        aeoi_isr_exp = 8'h04;
`endif
        chk("aeoi_isr", rd_data, aeoi_isr_exp);

        wr_ocw(2, 8'h20);
        ir = 8'h00;
        ticks(4);
        ir = 8'h01;
        ticks(5);
        chk("int_ir0", {7'd0, int_o}, 8'h01);
        inta_n = 1'b0;
        ticks(2);
        chk("int_drop_ack1", {7'd0, int_o}, 8'h00);
        chk("isr_ack1", rd_data, 8'h01);
        rst_n = 1'b0;
        #2;
        chk("midrst_int", {7'd0, int_o}, 8'h00);
        chk("midrst_vec", vec, 8'h00);
        chk("midrst_rd", rd_data, 8'h00);
        a0 = 1'b1;
        #1;
        chk("midrst_imr", rd_data, 8'h00);
        a0     = 1'b0;
        inta_n = 1'b1;
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
